alu_exec_unit: RTL

Multi-cycle execute stage that consumes the 4-bit ALU operation code emitted by the ALU control decoder, together with two operands, and produces the result, branch decision and completion strobe. It sits between the register-read stage and the writeback/PC-select logic. It closes the decoder's interface from the consuming side. Single-cycle ops finish in one cycle; SLL/SRL iterate one bit per cycle unless the barrel shifter is compiled in.

---
 rtl/alu_exec_pkg.sv | 30 +++
 rtl/alu_serial_shifter.sv | 42 ++++
 rtl/alu_exec_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute stage: op codes, FSM states, default width.
// Op code names follow the ALU control decoder's op set.
package alu_exec_pkg;

  localparam int ALU_DATA_WIDTH = 32;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_LUI     = 4'b0010;
  localparam logic [3:0] ALU_OR      = 4'b0011;
  localparam logic [3:0] ALU_SLL     = 4'b0100;
  localparam logic [3:0] ALU_SRL     = 4'b0101;
  localparam logic [3:0] ALU_AND     = 4'b0110;
  localparam logic [3:0] ALU_XOR     = 4'b0111;
  localparam logic [3:0] ALU_BEQ     = 4'b1000;
  localparam logic [3:0] ALU_BNE     = 4'b1001;
  localparam logic [3:0] ALU_BLT     = 4'b1010;
  localparam logic [3:0] ALU_SW      = 4'b1011;
  localparam logic [3:0] ALU_LW      = 4'b1100;
  localparam logic [3:0] ALU_JAL     = 4'b1101;
  localparam logic [3:0] ALU_JALR    = 4'b1110;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: load captures value/direction/amount, then shifts once per cycle.
// last flags the final step; shifted is the value after the current step.
module alu_serial_shifter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic                          left,
  input  logic [$clog2(DATA_WIDTH)-1:0] shamt,
  input  logic [DATA_WIDTH-1:0]         data,
  output logic                          busy,
  output logic                          last,
  output logic [DATA_WIDTH-1:0]         shifted
);

  localparam int SW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] work;
  logic [SW-1:0]         count;
  logic                  dir_left;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work     <= '0;
      count    <= '0;
      dir_left <= 1'b0;
    end else if (load) begin
      work     <= data;
      count    <= shamt;
      dir_left <= left;
    end else if (count != '0) begin
      work  <= shifted;
      count <= count - SW'(1);
    end
  end

  assign shifted = dir_left ? (work << 1) : (work >> 1);
  assign busy    = (count != '0);
  assign last    = (count == SW'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute stage: 1-cycle ops, serial SLL/SRL (1+shamt cycles) unless
// ALU_EXEC_BARREL_SHIFT_EN is defined, in which case every op takes 1 cycle. Requests only accepted in IDLE.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [3:0]            alu_op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  branch_taken_o,
  output logic                  illegal_o
);

  localparam int SW = $clog2(DATA_WIDTH);

  state_t                state;
  logic                  accept;
  logic                  serial_start;
  logic [SW-1:0]         shamt;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] diff;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_br;
  logic                  alu_ill;
  logic                  sh_busy;
  logic                  sh_last;
  logic [DATA_WIDTH-1:0] sh_shifted;

  assign accept = valid_i && ready_o;
  assign shamt  = b_i[SW-1:0];
  assign sum    = a_i + b_i;
  assign diff   = a_i - b_i;

  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    alu_ill = 1'b0;
    case (alu_op_i)
      ALU_ADD, ALU_SW, ALU_LW: alu_res = sum;
      ALU_SUB:  alu_res = diff;
      ALU_LUI:  alu_res = b_i;
      ALU_OR:   alu_res = a_i | b_i;
      ALU_AND:  alu_res = a_i & b_i;
      ALU_XOR:  alu_res = a_i ^ b_i;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
      ALU_SLL:  alu_res = a_i << shamt;
      ALU_SRL:  alu_res = a_i >> shamt;
`else
      // Only a zero-amount shift completes here; non-zero amounts go to the serial unit.
      ALU_SLL, ALU_SRL: alu_res = a_i;
`endif
      ALU_BEQ: begin
        alu_res = diff;
        alu_br  = (a_i == b_i);
      end
      ALU_BNE: begin
        alu_res = diff;
        alu_br  = (a_i != b_i);
      end
      ALU_BLT: begin
        alu_res = diff;
        alu_br  = ($signed(a_i) < $signed(b_i));
      end
      ALU_JAL:  alu_res = a_i + DATA_WIDTH'(4);
      ALU_JALR: alu_res = sum & ~DATA_WIDTH'(1);
      ALU_ILLEGAL: begin
        alu_res = '0;
        alu_ill = 1'b1;
      end
      default: begin
        alu_res = '0;
        alu_ill = 1'b1;
      end
    endcase
  end

`ifdef ALU_EXEC_BARREL_SHIFT_EN
  assign serial_start = 1'b0;
  assign sh_busy      = 1'b0;
  assign sh_last      = 1'b0;
  assign sh_shifted   = '0;
`else
  assign serial_start = accept && ((alu_op_i == ALU_SLL) || (alu_op_i == ALU_SRL))
                        && (shamt != '0);

  alu_serial_shifter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .load   (serial_start),
    .left   (alu_op_i == ALU_SLL),
    .shamt  (shamt),
    .data   (a_i),
    .busy   (sh_busy),
    .last   (sh_last),
    .shifted(sh_shifted)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      ready_o        <= 1'b1;
      done_o         <= 1'b0;
      result_o       <= '0;
      branch_taken_o <= 1'b0;
      illegal_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ready_o <= 1'b0;
            if (serial_start) begin
              state <= ST_SHIFT;
            end else begin
              state          <= ST_DONE;
              done_o         <= 1'b1;
              result_o       <= alu_res;
              branch_taken_o <= alu_br;
              illegal_o      <= alu_ill;
            end
          end
        end
        ST_SHIFT: begin
          // Leaving on !busy too keeps the FSM from stalling if the shifter is ever idle here.
          if (sh_last || !sh_busy) begin
            state          <= ST_DONE;
            done_o         <= 1'b1;
            result_o       <= sh_shifted;
            branch_taken_o <= 1'b0;
            illegal_o      <= 1'b0;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          ready_o <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
